pa_mem_arbiter: RTL and testbench

PA_MEM_ARBITER -- requirements
Module: pa_mem_arbiter

---
 rtl/pa_pkg.sv | 34 +++
 rtl/pa_rr_picker.sv | 51 +++++
 rtl/pa_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_pa_mem_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_pkg.sv
// Shared types and constants for the PA memory arbiter slice.
// Build option: PA_MEM_ARB_RR_EN selects round-robin arbitration (default fixed priority).
package pa_pkg;

  localparam int unsigned PHY_ADDR_LEN = 32;
  localparam int unsigned XLEN         = 32;

  // Memory request payload as seen on the memory side
  typedef struct packed {
    logic                    valid;
    logic                    we;
    logic [PHY_ADDR_LEN-1:0] addr;
    logic [XLEN-1:0]         wdata;
  } mem_req_t;

  // Memory response payload
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rdata;
  } mem_resp_t;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Width of a channel index; never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pa_rr_picker.sv
// Rotating priority picker: first requesting channel at or after i_start wins.
// Passing i_start = 0 gives plain lowest-index-first priority.
module pa_rr_picker
  import pa_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_start,
  output logic [NUM_CH-1:0] o_gnt_c,
  output logic [IDX_W-1:0]  o_idx_c,
  output logic              o_any_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [NUM_CH-1:0] w_req_rot;
  logic [SUM_W-1:0]  w_sum;

  // Rotate the request vector so bit 0 is the start channel
  always_comb begin
    w_req_rot = NUM_CH'({i_req, i_req} >> i_start);
  end

  // First set bit of the rotated vector wins; map it back to a channel number
  always_comb begin
    o_any_c = 1'b0;
    o_idx_c = '0;
    w_sum   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!o_any_c && w_req_rot[k]) begin
        o_any_c = 1'b1;
        w_sum   = SUM_W'(i_start) + SUM_W'(k);
        if (w_sum >= SUM_W'(NUM_CH)) begin
          w_sum = w_sum - SUM_W'(NUM_CH);
        end
        o_idx_c = IDX_W'(w_sum);
      end
    end
  end

  // One-hot form of the winning channel
  always_comb begin
    o_gnt_c = '0;
    if (o_any_c) begin
      o_gnt_c = NUM_CH'(1) << o_idx_c;
    end
  end

endmodule

// File: rtl/pa_mem_arbiter.sv
// Multi-channel arbiter in front of a single-outstanding memory port.
// Build option: PA_MEM_ARB_RR_EN enables round-robin arbitration; without it
// the lowest requesting channel always wins and no rotation pointer exists.
module pa_mem_arbiter
  import pa_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = PHY_ADDR_LEN,
  parameter int unsigned DATA_W = XLEN
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [NUM_CH-1:0]              ch_req_valid_i,
  input  logic [NUM_CH-1:0]              ch_req_we_i,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_req_addr_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_req_wdata_i,
  output logic [NUM_CH-1:0]              ch_resp_valid_o,
  output logic [DATA_W-1:0]              ch_resp_rdata_o,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic                           mem_req_we_o,
  output logic [ADDR_W-1:0]              mem_req_addr_o,
  output logic [DATA_W-1:0]              mem_req_wdata_o,
  input  logic                           mem_resp_valid_i,
  input  logic [DATA_W-1:0]              mem_resp_rdata_i
);

  localparam int unsigned IDX_W = idx_width(NUM_CH);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [IDX_W-1:0]    w_grant_idx_nxt;
  logic                r_we;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic                r_req_valid;
  logic                w_req_valid_nxt;
  logic [NUM_CH-1:0]   r_resp_valid;
  logic [NUM_CH-1:0]   w_resp_valid_nxt;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic [DATA_W-1:0]   w_resp_rdata_nxt;

  logic [IDX_W-1:0]    w_pick_start;
  logic [NUM_CH-1:0]   w_pick_gnt;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;

`ifdef PA_MEM_ARB_RR_EN
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    w_rr_ptr_nxt;

  // Search begins just after the most recently granted channel
  always_comb begin
    w_pick_start = r_rr_ptr;
  end
`else
  // Fixed priority: search always begins at channel 0
  always_comb begin
    w_pick_start = '0;
  end
`endif

  pa_rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .i_req   (ch_req_valid_i),
    .i_start (w_pick_start),
    .o_gnt_c (w_pick_gnt),
    .o_idx_c (w_pick_idx),
    .o_any_c (w_pick_any)
  );

  // Next-state and registered-output logic for one transaction at a time
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_idx_nxt  = r_grant_idx;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_req_valid_nxt  = 1'b0;
    w_resp_valid_nxt = '0;
    w_resp_rdata_nxt = r_resp_rdata;
`ifdef PA_MEM_ARB_RR_EN
    w_rr_ptr_nxt     = r_rr_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt     = ISSUE;
          w_req_valid_nxt = 1'b1;
          w_grant_idx_nxt = w_pick_idx;
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_pick_gnt[c]) begin
              w_we_nxt    = ch_req_we_i[c];
              w_addr_nxt  = ch_req_addr_i[c];
              w_wdata_nxt = ch_req_wdata_i[c];
            end
          end
`ifdef PA_MEM_ARB_RR_EN
          w_rr_ptr_nxt = (w_pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_pick_idx + IDX_W'(1);
`endif
        end
      end
      ISSUE: begin
        if (mem_req_ready_i) begin
          w_state_nxt = WAIT;
        end else begin
          w_req_valid_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (mem_resp_valid_i) begin
          w_state_nxt      = IDLE;
          w_resp_valid_nxt = NUM_CH'(1) << r_grant_idx;
          w_resp_rdata_nxt = mem_resp_rdata_i;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and payload registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state      <= IDLE;
      r_grant_idx  <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req_valid  <= 1'b0;
      r_resp_valid <= '0;
      r_resp_rdata <= '0;
`ifdef PA_MEM_ARB_RR_EN
      r_rr_ptr     <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_grant_idx  <= w_grant_idx_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_req_valid  <= w_req_valid_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
`ifdef PA_MEM_ARB_RR_EN
      r_rr_ptr     <= w_rr_ptr_nxt;
`endif
    end
  end

  assign mem_req_valid_o = r_req_valid;
  assign mem_req_we_o    = r_we;
  assign mem_req_addr_o  = r_addr;
  assign mem_req_wdata_o = r_wdata;
  assign ch_resp_valid_o = r_resp_valid;
  assign ch_resp_rdata_o = r_resp_rdata;

endmodule

// File: tb/tb_pa_mem_arbiter.sv
// Self-checking bench for pa_mem_arbiter with a transaction-level reference model.
// Honours PA_MEM_ARB_RR_EN the same way as the design.
module tb_pa_mem_arbiter;

  logic             clk;
  logic             rstn;
  logic [2:0]       ch_req_valid;
  logic [2:0]       ch_req_we;
  logic [2:0][31:0] ch_req_addr;
  logic [2:0][31:0] ch_req_wdata;
  logic [2:0]       ch_resp_valid;
  logic [31:0]      ch_resp_rdata;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_req_we;
  logic [31:0]      mem_req_addr;
  logic [31:0]      mem_req_wdata;
  logic             mem_resp_valid;
  logic [31:0]      mem_resp_rdata;

  pa_mem_arbiter #(
    .NUM_CH (3),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .ch_req_valid_i   (ch_req_valid),
    .ch_req_we_i      (ch_req_we),
    .ch_req_addr_i    (ch_req_addr),
    .ch_req_wdata_i   (ch_req_wdata),
    .ch_resp_valid_o  (ch_resp_valid),
    .ch_resp_rdata_o  (ch_resp_rdata),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_we_o     (mem_req_we),
    .mem_req_addr_o   (mem_req_addr),
    .mem_req_wdata_o  (mem_req_wdata),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_rdata_i (mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs;
  int errs;

  // Reference model: who owns the memory port and whether it has been accepted
  bit          busy;
  bit          accepted;
  int          own;
  int          ptr;
  int          resp_cnt;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_rdata;
  int          model_strobes;

  // Observations of the DUT
  int          dut_valid_cycles;
  int          dut_accepts;
  int          strobe_log[$];

  // Stimulus knobs
  int          ready_pct;
  int          max_delay;
  int          stray_pct;
  int          req_mode;   // 0 hold, 1 drop on own strobe, 2 random traffic
  bit          resp_en;
  bit          use_fix;
  logic [31:0] fix_rdata;

  // Winner among requesting channels, searching from 'start' with wrap-around
  function automatic int pick(input logic [2:0] req, input int start);
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (start + k) % 3;
      if (((req >> c) & 3'b001) != 3'b000) return c;
    end
    return -1;
  endfunction

  task automatic new_request(input int c);
    ch_req_valid[c] = 1'b1;
    ch_req_we[c]    = 1'($urandom_range(1, 0));
    ch_req_addr[c]  = $urandom;
    ch_req_wdata[c] = $urandom;
  endtask

  // One clock: advance model, check DUT, then drive requesters and memory
  task automatic do_cycle();
    logic [2:0] exp_strobe;
    bit         exp_mv;
    int         w;
    exp_strobe = 3'b000;
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) dut_accepts++;
    if (!busy) begin
      w = pick(ch_req_valid, ptr);
      if (w >= 0) begin
        busy      = 1'b1;
        accepted  = 1'b0;
        own       = w;
        exp_we    = ch_req_we[w];
        exp_addr  = ch_req_addr[w];
        exp_wdata = ch_req_wdata[w];
`ifdef PA_MEM_ARB_RR_EN
        ptr = (w + 1) % 3;
`endif
      end
    end else if (!accepted) begin
      if (mem_req_ready) begin
        accepted = 1'b1;
        resp_cnt = $urandom_range(max_delay, 0);
      end
    end else if (mem_resp_valid) begin
      exp_strobe = 3'b001 << own;
      exp_rdata  = mem_resp_rdata;
      busy       = 1'b0;
      accepted   = 1'b0;
      model_strobes++;
    end

    @(posedge clk);
    #1;
    exp_mv = busy && !accepted;
    vecs++;
    if (mem_req_valid !== exp_mv) begin
      errs++;
      $display("FAIL mem_req_valid: got %b want %b at %0t", mem_req_valid, exp_mv, $time);
    end
    if (exp_mv) begin
      vecs++;
      if ({mem_req_we, mem_req_addr, mem_req_wdata} !== {exp_we, exp_addr, exp_wdata}) begin
        errs++;
        $display("FAIL mem_req_payload: got we=%b a=%h d=%h want we=%b a=%h d=%h at %0t",
                 mem_req_we, mem_req_addr, mem_req_wdata, exp_we, exp_addr, exp_wdata, $time);
      end
    end
    vecs++;
    if (ch_resp_valid !== exp_strobe) begin
      errs++;
      $display("FAIL ch_resp_valid: got %b want %b at %0t", ch_resp_valid, exp_strobe, $time);
    end
    vecs++;
    if (ch_resp_rdata !== exp_rdata) begin
      errs++;
      $display("FAIL ch_resp_rdata: got %h want %h at %0t", ch_resp_rdata, exp_rdata, $time);
    end
    if (mem_req_valid === 1'b1) dut_valid_cycles++;
    for (int c = 0; c < 3; c++) begin
      if (ch_resp_valid[c] === 1'b1) strobe_log.push_back(c);
    end

    for (int c = 0; c < 3; c++) begin
      if (exp_strobe[c]) begin
        if (req_mode == 1) begin
          ch_req_valid[c] = 1'b0;
        end else if (req_mode == 2) begin
          if ($urandom_range(1, 0) == 0) ch_req_valid[c] = 1'b0;
          else new_request(c);
        end
      end else if (req_mode == 2 && ch_req_valid[c] == 1'b0 && $urandom_range(99, 0) < 30) begin
        new_request(c);
      end
    end

    mem_req_ready  = ($urandom_range(99, 0) < ready_pct);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = $urandom;
    if (busy && accepted) begin
      if (resp_en) begin
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          if (use_fix) mem_resp_rdata = fix_rdata;
        end else begin
          resp_cnt--;
        end
      end
    end else if ($urandom_range(99, 0) < stray_pct) begin
      mem_resp_valid = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rstn           = 1'b0;
    ch_req_valid   = 3'($urandom);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = $urandom;
    mem_req_ready  = 1'b1;
    busy           = 1'b0;
    accepted       = 1'b0;
    ptr            = 0;
    exp_rdata      = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      vecs++;
      if ({mem_req_valid, ch_resp_valid, ch_resp_rdata} !== 36'd0) begin
        errs++;
        $display("FAIL reset_outputs: got v=%b s=%b r=%h want all zero", mem_req_valid, ch_resp_valid, ch_resp_rdata);
      end
      vecs++;
      if ({mem_req_we, mem_req_addr, mem_req_wdata} !== 65'd0) begin
        errs++;
        $display("FAIL reset_payload: got we=%b a=%h d=%h want zero", mem_req_we, mem_req_addr, mem_req_wdata);
      end
    end
    ch_req_valid   = 3'b000;
    mem_resp_valid = 1'b0;
    rstn           = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) do_cycle();
  endtask

  task automatic test_single_read();
    int  lat;
    bit  seen;
    apply_reset();
    ready_pct = 100; max_delay = 0; stray_pct = 0; resp_en = 1'b1;
    use_fix = 1'b1; fix_rdata = 32'hDEADBEEF; req_mode = 1;
    mem_req_ready   = 1'b1;
    ch_req_valid    = 3'b010;
    ch_req_we[1]    = 1'b0;
    ch_req_addr[1]  = 32'h0000_1000;
    ch_req_wdata[1] = $urandom;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      do_cycle();
      lat++;
      if (ch_resp_valid !== 3'b000) seen = 1'b1;
    end
    vecs++;
    if (lat != 3 || ch_resp_valid !== 3'b010) begin
      errs++;
      $display("FAIL single_read_latency: got %0d cycles strobe %b want 3 cycles strobe 010", lat, ch_resp_valid);
    end
    vecs++;
    if (ch_resp_rdata !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL single_read_rdata: got %h want deadbeef", ch_resp_rdata);
    end
    use_fix = 1'b0;
    repeat (3) do_cycle();
  endtask

  task automatic test_arb_order();
    int exp_seq[4];
`ifdef PA_MEM_ARB_RR_EN
    exp_seq = '{0, 1, 2, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    apply_reset();
    ready_pct = 100; max_delay = 0; stray_pct = 0; resp_en = 1'b1; req_mode = 0;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 3; c++) new_request(c);
    strobe_log.delete();
    for (int i = 0; i < 40 && strobe_log.size() < 4; i++) do_cycle();
    ch_req_valid = 3'b000;
    vecs++;
    if (strobe_log.size() != 4) begin
      errs++;
      $display("FAIL arb_order_count: got %0d strobes want 4", strobe_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (strobe_log[i] != exp_seq[i]) begin
          errs++;
          $display("FAIL arb_order[%0d]: got ch%0d want ch%0d", i, strobe_log[i], exp_seq[i]);
        end
      end
    end
    repeat (3) do_cycle();
  endtask

  task automatic test_write_stall();
    apply_reset();
    ready_pct = 0; max_delay = 0; stray_pct = 0; resp_en = 1'b1; req_mode = 1;
    mem_req_ready   = 1'b0;
    ch_req_valid    = 3'b100;
    ch_req_we[2]    = 1'b1;
    ch_req_addr[2]  = 32'h0000_8000;
    ch_req_wdata[2] = 32'h1234_5678;
    dut_valid_cycles = 0;
    dut_accepts      = 0;
    strobe_log.delete();
    repeat (4) do_cycle();
    ready_pct = 100;
    repeat (6) do_cycle();
    vecs++;
    if (dut_valid_cycles != 5) begin
      errs++;
      $display("FAIL write_stall_valid_cycles: got %0d want 5", dut_valid_cycles);
    end
    vecs++;
    if (dut_accepts != 1) begin
      errs++;
      $display("FAIL write_stall_accepts: got %0d want 1", dut_accepts);
    end
    vecs++;
    if (strobe_log.size() != 1 || strobe_log[0] != 2) begin
      errs++;
      $display("FAIL write_stall_strobe: got %0d strobes (first ch%0d) want 1 on ch2",
               strobe_log.size(), (strobe_log.size() > 0) ? strobe_log[0] : -1);
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    ready_pct = 100; max_delay = 0; stray_pct = 0; resp_en = 1'b0; req_mode = 0;
    mem_req_ready = 1'b1;
    new_request(1);
    for (int i = 0; i < 10 && !(busy && accepted); i++) do_cycle();
    vecs++;
    if (!(busy && accepted)) begin
      errs++;
      $display("FAIL reset_wait_setup: got no accepted request want one within 10 cycles");
    end
    apply_reset();
    stray_pct = 100; req_mode = 1;
    strobe_log.delete();
    repeat (5) do_cycle();
    vecs++;
    if (strobe_log.size() != 0) begin
      errs++;
      $display("FAIL reset_wait_stray: got %0d strobes want 0", strobe_log.size());
    end
    stray_pct = 0;
    resp_en   = 1'b1;
  endtask

  task automatic test_drop_mid();
    apply_reset();
    ready_pct = 100; max_delay = 0; stray_pct = 0; resp_en = 1'b0; req_mode = 0;
    mem_req_ready = 1'b1;
    new_request(0);
    for (int i = 0; i < 10 && !(busy && accepted); i++) do_cycle();
    ch_req_valid[0]  = 1'b0;
    resp_en          = 1'b1;
    strobe_log.delete();
    dut_valid_cycles = 0;
    repeat (6) do_cycle();
    vecs++;
    if (strobe_log.size() != 1 || strobe_log[0] != 0) begin
      errs++;
      $display("FAIL drop_mid_strobe: got %0d strobes (first ch%0d) want 1 on ch0",
               strobe_log.size(), (strobe_log.size() > 0) ? strobe_log[0] : -1);
    end
    vecs++;
    if (dut_valid_cycles != 0) begin
      errs++;
      $display("FAIL drop_mid_reissue: got %0d request cycles want 0", dut_valid_cycles);
    end
  endtask

  task automatic test_random();
    apply_reset();
    ready_pct = 60; max_delay = 3; stray_pct = 10; resp_en = 1'b1; use_fix = 1'b0; req_mode = 2;
    strobe_log.delete();
    model_strobes = 0;
    repeat (2000) do_cycle();
    vecs++;
    if (strobe_log.size() != model_strobes) begin
      errs++;
      $display("FAIL random_strobe_total: got %0d want %0d", strobe_log.size(), model_strobes);
    end
    req_mode = 1;
    ch_req_valid = 3'b000;
    repeat (20) do_cycle();
  endtask

  initial begin
    vecs = 0; errs = 0;
    busy = 1'b0; accepted = 1'b0; own = 0; ptr = 0; resp_cnt = 0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    model_strobes = 0; dut_valid_cycles = 0; dut_accepts = 0;
    ready_pct = 100; max_delay = 0; stray_pct = 0; req_mode = 1;
    resp_en = 1'b1; use_fix = 1'b0; fix_rdata = '0;
    rstn = 1'b0;
    ch_req_valid = '0; ch_req_we = '0; ch_req_addr = '0; ch_req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

    test_reset();
    test_single_read();
    test_arb_order();
    test_write_stall();
    test_reset_in_wait();
    test_drop_mid();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
